rho_pi_round: RTL and testbench

Keccak-f[1600] ρ+π stage, directly downstream of the θ stage: it consumes the 1600-bit θ result and produces the rotated, permuted state for the χ stage. Both neighbours use the same start/done handshake. Processing is row-serial: one source row (five lanes) per cycle, giving a fixed latency and sharing five 64-bit rotators across all 25 lanes.

---
 rtl/rho_pi_round.sv | 92 +++++++++
 tb/tb_rho_pi_round.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rho_pi_round.sv
// Keccak-f[1600] rho+pi stage: captures the theta result, then rotates and permutes
// one source row (five lanes) per cycle through five shared 64-bit rotators.
module rho_pi_round (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1599:0] state_in,
    output logic          busy,
    output logic          done,
    output logic [1599:0] rho_pi_out
);

    typedef enum logic [1:0] {IDLE, ROW, DONE} state_t;

    // Rotation offsets r[x][y].
    localparam logic [5:0] ROT_OFF [5][5] = '{
        '{6'd0,  6'd36, 6'd3,  6'd41, 6'd18},
        '{6'd1,  6'd44, 6'd10, 6'd45, 6'd2 },
        '{6'd62, 6'd6,  6'd43, 6'd15, 6'd61},
        '{6'd28, 6'd55, 6'd25, 6'd21, 6'd56},
        '{6'd27, 6'd20, 6'd39, 6'd8,  6'd14}
    };

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_y;
    logic [1599:0]   r_in;
    logic [1599:0]   r_out;
    logic [1599:0]   w_out_next;
    logic [63:0]     w_src;
    logic [127:0]    w_dbl;
    logic [63:0]     w_rot [5];

    // Output lane (x',y') = j is fed, while row y = x' is processed, by source
    // column x solving 2x + 3y = y' (mod 5); 3 is the inverse of 2 mod 5.
    function automatic int src_x(input int j);
        return (3 * ((j / 5) - 3 * (j % 5) + 15)) % 5;
    endfunction

    always_comb begin
        w_src = '0;
        w_dbl = '0;
        for (int x = 0; x < 5; x++) begin
            w_src    = r_in[64*(5*int'(r_y) + x) +: 64];
            w_dbl    = {w_src, w_src} << ROT_OFF[x][r_y];
            w_rot[x] = w_dbl[127:64];
        end
    end

    always_comb begin
        w_out_next = r_out;
        if (r_state == ROW) begin
            for (int j = 0; j < 25; j++) begin
                if (int'(r_y) == (j % 5))
                    w_out_next[64*j +: 64] = w_rot[src_x(j)];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ROW;
            ROW:     if (r_y == 3'd4) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= 3'd0;
            r_in    <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if (r_state == IDLE && start) begin
                r_in <= state_in;
                r_y  <= 3'd0;
            end else if (r_state == ROW && r_y != 3'd4) begin
                r_y <= r_y + 3'd1;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign rho_pi_out = r_out;

endmodule

// File: tb/tb_rho_pi_round.sv
// Bench for rho_pi_round: a driver issues operations and queues the expected result,
// a monitor pops and compares whenever done is high.
module tb_rho_pi_round;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1599:0] state_in;
    logic          busy;
    logic          done;
    logic [1599:0] rho_pi_out;

    int n_vec = 0;
    int n_err = 0;
    logic [1599:0] exp_q[$];
    logic          prev_done;

    rho_pi_round dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state_in   (state_in),
        .busy       (busy),
        .done       (done),
        .rho_pi_out (rho_pi_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [5:0] roff(input int x, input int y);
        logic [5:0] t [25];
        t = '{6'd0, 6'd36, 6'd3, 6'd41, 6'd18,
              6'd1, 6'd44, 6'd10, 6'd45, 6'd2,
              6'd62, 6'd6, 6'd43, 6'd15, 6'd61,
              6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
              6'd27, 6'd20, 6'd39, 6'd8, 6'd14};
        return t[5*x + y];
    endfunction

    function automatic logic [1599:0] model(input logic [1599:0] a);
        logic [1599:0] b;
        logic [63:0]   lane;
        int            s;
        int            yd;
        b = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                lane = a[64*(5*y + x) +: 64];
                s    = int'(roff(x, y));
                if (s != 0) lane = (lane << s) | (lane >> (64 - s));
                yd   = (2*x + 3*y) % 5;
                b[64*(5*yd + y) +: 64] = lane;
            end
        end
        return b;
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [1599:0] got, input logic [1599:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            for (int j = 0; j < 25; j++) begin
                if (got[64*j +: 64] !== exp[64*j +: 64]) begin
                    $display("FAIL %s: lane %0d got %h expected %h at %0t",
                             name, j, got[64*j +: 64], exp[64*j +: 64], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (done) begin
            chk_bit("done_width", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                chk_wide("result", rho_pi_out, exp_q.pop_front());
            end
        end
        prev_done <= done;
    end

    // ---------------- driver ----------------
    // Starts in the negedge slot of the current idle cycle. Changes state_in in
    // cycle 1; optionally raises start in cycles 2 and 6 (must be ignored).
    task automatic run_op(input logic [1599:0] v, input logic [1599:0] e, input bit extra);
        @(negedge clk);
        chk_bit("idle_busy", busy, 1'b0);
        chk_bit("idle_done", done, 1'b0);
        state_in = v;
        start    = 1'b1;
        exp_q.push_back(e);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) state_in = ~v;
            if (extra && (c == 2 || c == 6)) begin
                start    = 1'b1;
                state_in = {50{32'hDEADBEEF}};
            end
            chk_bit($sformatf("busy_c%0d", c), busy, 1'b1);
            chk_bit($sformatf("done_c%0d", c), done, (c == 6));
        end
        if (extra) begin
            @(negedge clk);
            start = 1'b0;
            chk_bit("c7_busy", busy, 1'b0);
            chk_bit("c7_done", done, 1'b0);
            repeat (8) @(negedge clk);
            chk_bit("no_second_op", busy, 1'b0);
        end
    endtask

    initial begin
        logic [1599:0] v;
        logic [1599:0] e;
        rst = 1'b1;
        start = 1'b0;
        state_in = '0;
        repeat (3) @(negedge clk);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_wide("rst_out", rho_pi_out, '0);
        rst = 1'b0;

        // zero state
        run_op('0, '0, 1'b0);

        // single-bit routing, hand-computed destinations
        v = '0; v[0] = 1'b1;            e = '0; e[0] = 1'b1;
        run_op(v, e, 1'b0);
        v = '0; v[64*1] = 1'b1;         e = '0; e[64*10 + 1] = 1'b1;
        run_op(v, e, 1'b0);
        v = '0; v[64*12] = 1'b1;        e = '0; e[64*2 + 43] = 1'b1;
        run_op(v, e, 1'b0);
        v = '0; v[64*24 + 63] = 1'b1;   e = '0; e[64*4 + 13] = 1'b1;
        run_op(v, e, 1'b0);

        // starts while busy are ignored
        v = {25{64'h0123456789ABCDEF}}; e = '0;
        for (int j = 0; j < 25; j++) v[64*j +: 64] = v[64*j +: 64] ^ 64'(j);
        run_op(v, model(v), 1'b1);

        // reset mid-operation
        @(negedge clk);
        state_in = {50{32'hA5A5_5A5A}};
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_done", done, 1'b0);
        chk_wide("midrst_out", rho_pi_out, '0);

        // rst and start together: start dropped
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk_bit("rst_start_busy", busy, 1'b0);

        // fresh run after reset, then random back-to-back
        v = {50{32'h1357_9BDF}};
        run_op(v, model(v), 1'b0);
        for (int n = 0; n < 200; n++) begin
            for (int w = 0; w < 50; w++) v[32*w +: 32] = $urandom;
            run_op(v, model(v), 1'b0);
        end

        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending: got %0d results outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
